// File: rtl/pipeline_hazard_controller.sv
// Pipeline hazard controller: load-use / flag stalls, redirect flushes,
// EX-operand forward-select generation, debug halt/step FSM and
// saturating stall/flush performance counters.
module pipeline_hazard_controller #(
  parameter int REG_ID_LEN = 3,
  parameter int CNT_LEN    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ID_LEN-1:0] id_rs1,
  input  logic [REG_ID_LEN-1:0] id_rs2,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  input  logic                  id_redirect,
  input  logic                  id_flag_branch,
  input  logic [REG_ID_LEN-1:0] ex_rd,
  input  logic                  ex_rf_write_en,
  input  logic                  ex_mem_read,
  input  logic                  ex_sets_flags,
  input  logic [REG_ID_LEN-1:0] mem_rd,
  input  logic                  mem_rf_write_en,
  input  logic [REG_ID_LEN-1:0] wb_rd,
  input  logic                  wb_rf_write_en,
  input  logic                  dbg_halt_req,
  input  logic                  dbg_step,
  output logic                  pc_ld,
  output logic                  pr1_ld,
  output logic                  pr1_flush,
  output logic                  pr2_flush,
  output logic [1:0]            fwd_a_sel,
  output logic [1:0]            fwd_b_sel,
  output logic                  halted,
  output logic [CNT_LEN-1:0]    stall_count,
  output logic [CNT_LEN-1:0]    flush_count
);

  typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;

  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_MEM = 2'b01;
  localparam logic [1:0] SEL_WB  = 2'b10;

  state_t               state_q, state_d;
  logic [1:0]           fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
  logic [CNT_LEN-1:0]   stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
  logic                 load_use, flag_haz, halt_bubble, stall, redirect;
  logic [1:0]           fwd_a_id, fwd_b_id;

  // WB producers are covered by register-file write-before-read, so they
  // only appear here to keep every input observed.
  logic                 wb_unused;
  assign wb_unused = wb_rf_write_en & (|wb_rd);

  // Hazard detection in ID against the instruction currently in EX
  always_comb begin
    load_use = ex_mem_read & ex_rf_write_en &
               ((id_uses_rs1 & (id_rs1 == ex_rd)) |
                (id_uses_rs2 & (id_rs2 == ex_rd)));
    flag_haz = id_flag_branch & ex_sets_flags;
  end

  // Forward select per source: the EX producer (one stage younger) wins
  // over the MEM producer; loads in EX are excluded since they stall.
  always_comb begin
    fwd_a_id = SEL_RF;
    if (id_uses_rs1 & ex_rf_write_en & ~ex_mem_read & (id_rs1 == ex_rd))
      fwd_a_id = SEL_MEM;
    else if (id_uses_rs1 & mem_rf_write_en & (id_rs1 == mem_rd))
      fwd_a_id = SEL_WB;
    fwd_b_id = SEL_RF;
    if (id_uses_rs2 & ex_rf_write_en & ~ex_mem_read & (id_rs2 == ex_rd))
      fwd_b_id = SEL_MEM;
    else if (id_uses_rs2 & mem_rf_write_en & (id_rs2 == mem_rd))
      fwd_b_id = SEL_WB;
  end

  // FSM next state and cycle classification: halt bubble > stall > redirect > normal.
  // Reset forces the normal class so the front end free-runs while held.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:     if (dbg_halt_req)  state_d = HALT;
      HALT:    if (!dbg_halt_req) state_d = RUN;
      default: state_d = RUN;
    endcase

    halt_bubble = ~rst & (state_q == HALT) & ~dbg_step;
    stall       = ~rst & ~halt_bubble & (load_use | flag_haz);
    redirect    = ~rst & ~halt_bubble & ~stall & id_redirect;

    pc_ld     = ~(halt_bubble | stall);
    pr1_ld    = ~(halt_bubble | stall);
    pr1_flush = redirect;
    pr2_flush = halt_bubble | stall;
  end

  // Next values for registered selects and saturating counters
  always_comb begin
    fwd_a_d     = pr2_flush ? SEL_RF : fwd_a_id;
    fwd_b_d     = pr2_flush ? SEL_RF : fwd_b_id;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall & ~(&stall_cnt_q))    stall_cnt_d = stall_cnt_q + CNT_LEN'(1);
    if (redirect & ~(&flush_cnt_q)) flush_cnt_d = flush_cnt_q + CNT_LEN'(1);
  end

  // State, forward-select and counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RUN;
      fwd_a_q     <= SEL_RF;
      fwd_b_q     <= SEL_RF;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      fwd_a_q     <= fwd_a_d;
      fwd_b_q     <= fwd_b_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign halted      = (state_q == HALT);
  assign fwd_a_sel   = fwd_a_q;
  assign fwd_b_sel   = fwd_b_q;
  assign stall_count = stall_cnt_q;
  assign flush_count = flush_cnt_q;

endmodule

// File: doc/pipeline_hazard_controller.md
PIPELINE_HAZARD_CONTROLLER -- requirements
Module: pipeline_hazard_controller

Interface
REQ-001 Parameter: REG_ID_LEN, default 3, width of register-file indices.
REQ-002 Parameter: CNT_LEN, default 16, width of performance counters.
REQ-003 The block SHALL have exactly one clock, clk, and its reset, rst, SHALL be asynchronous and active-high.
REQ-004 Ports SHALL be as follows (name  direction  width  meaning):
- clk  in  1  clock.
- rst  in  1  async active-high reset.
- id_rs1, id_rs2  in  REG_ID_LEN  ID-stage source register indices.
- id_uses_rs1, id_uses_rs2  in  1  ID instruction reads that source.
- id_redirect  in  1  ID instruction changes PC (jump, taken branch, call, ret).
- id_flag_branch  in  1  ID instruction is a C/Z-conditional branch.
- ex_rd  in  REG_ID_LEN  EX destination.
- ex_rf_write_en, ex_mem_read, ex_sets_flags  in  1  EX control.
- mem_rd  in  REG_ID_LEN  MEM destination.
- mem_rf_write_en  in  1  MEM control.
- wb_rd  in  REG_ID_LEN  WB destination.
- wb_rf_write_en  in  1  WB control.
- dbg_halt_req  in  1  level halt request.
- dbg_step  in  1  single-cycle step pulse.
- pc_ld  out  1  PC register load enable.
- pr1_ld  out  1  IF/ID register load enable.
- pr1_flush  out  1  clear IF/ID to NOP.
- pr2_flush  out  1  insert bubble into ID/EX.
- fwd_a_sel, fwd_b_sel  out  2  EX operand source: 00 RF, 01 MEM alu_out, 10 WB write data.
- halted  out  1  FSM in HALT.
- stall_count, flush_count  out  CNT_LEN  performance counters.

Function
REQ-005 FSM states SHALL be RUN and HALT only; state register clocked on clk rising edge.
REQ-006 Transitions: RUN->HALT when dbg_halt_req=1 at a clock edge; HALT->RUN when dbg_halt_req=0 at a clock edge; otherwise hold.
REQ-007 load_use SHALL be 1 when ex_mem_read & ex_rf_write_en & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)).
REQ-008 flag_haz SHALL be 1 when id_flag_branch & ex_sets_flags.
REQ-009 Cycle classes SHALL be prioritised: HALT-without-step > load_use > flag_haz > id_redirect > normal; stall/flush outputs SHALL be combinational from state and current inputs (zero latency).
REQ-010 HALT with dbg_step=0: pc_ld=0, pr1_ld=0, pr1_flush=0, pr2_flush=1.
REQ-011 HALT with dbg_step=1: that cycle SHALL be evaluated exactly as in RUN (hazard rules apply).
REQ-012 Stall (load_use or flag_haz): pc_ld=0, pr1_ld=0, pr1_flush=0, pr2_flush=1; id_redirect SHALL be ignored that cycle.
REQ-013 Redirect: pc_ld=1, pr1_ld=1, pr1_flush=1, pr2_flush=0.
REQ-014 Normal: pc_ld=1, pr1_ld=1, pr1_flush=0, pr2_flush=0.
REQ-015 Forward selects SHALL be computed in ID and registered into fwd_*_sel on every edge where pr2_flush=0; on pr2_flush=1 they SHALL load 00.
REQ-016 Per source x: sel=01 if id_uses_rsx & mem... no -- sel=01 if id_uses_rsx & ex_rf_write_en & ~ex_mem_read & id_rsx==ex_rd (producer reaches MEM next cycle); else 10 if id_uses_rsx & mem_rf_write_en & id_rsx==mem_rd; else 00. The EX match SHALL win over the MEM match.
REQ-017 WB-to-ID hazard SHALL NOT be forwarded; the register file write-before-read covers it.
REQ-018 stall_count SHALL increment on each stall cycle (REQ-012); flush_count SHALL increment on each redirect cycle (REQ-013); HALT bubbles SHALL NOT count; both saturate at all-ones.

Reset
REQ-019 While rst=1 (asynchronous): state=RUN, halted=0, fwd_a_sel=fwd_b_sel=00, stall_count=flush_count=0.
REQ-020 During rst=1, pc_ld, pr1_ld, pr1_flush, pr2_flush SHALL follow REQ-014 evaluation of RUN; reset mid-HALT SHALL return to RUN immediately.

Verification
REQ-021 Load-use: EX lw rd=3, ID add rs1=3 -> one cycle pc_ld=0, pr2_flush=1, stall_count 0->1; next cycle normal, fwd_a_sel=10 registered.
REQ-022 ALU forward: EX add rd=2 (no mem_read), ID rs2=2, MEM rd=2 also writing -> fwd_b_sel=01 next cycle.
REQ-023 Flag branch: ex_sets_flags=1, id_flag_branch=1, id_redirect=1 -> stall cycle (pr1_flush=0); next cycle with ex_sets_flags=0 -> pr1_flush=1, flush_count=1.
REQ-024 Halt/step: dbg_halt_req=1 for 5 cycles with dbg_step pulsed once in cycle 3 -> halted=1 from cycle 2, exactly one cycle pc_ld=1, counters unchanged by bubbles.
REQ-025 Saturation: preload by 65535 stalls -> further stall keeps stall_count=16'hFFFF.
REQ-026 Async reset asserted mid-HALT, between edges -> halted=0, counters=0, selects=00 without a clock edge.
